// File: rtl/uart_rx_port.sv
// uart_rx_port: bus-slave UART receiver. Samples RxD through a 2-flop synchronizer, deframes
// 8N1 bytes with an oversampling FSM and buffers them in a FIFO that the CPU polls over the
// shared tri-state bus.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   address    bus address; decode window BASE_ADDR..BASE_ADDR+15, register select address[1:0]
//   data       bus data; driven only while selected for a read, else 'z
//   request    bus request
//   r_w        1 = write, 0 = read
//   ready_out  1 while selected, else 'z
//   RxD        asynchronous serial input, idle high
//   RxD_ready  FIFO not empty
//   irq        (UART_RX_IRQ_EN only) registered irq_en & (not_empty | overrun)
//
// Registers: 00 DATA (read pops), 01 STAT (write 1 to bit1/bit2 clears frame_err/overrun),
// 10 CTRL (bit0 irq_en when UART_RX_IRQ_EN is defined, otherwise reads 0), 11 reads 0.
// Optional feature macro: UART_RX_IRQ_EN.
module uart_rx_port #(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 921600,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3fffffe0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    inout  wire  [31:0] data,
    input  logic        request,
    input  logic        r_w,
    output logic        ready_out,
    input  logic        RxD,
    output logic        RxD_ready
`ifdef UART_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned CLKS_PER_BIT = (ClkFrequency + Baud / 2) / Baud;
    localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [15:0] CNT_HALF     = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] CNT_LAST     = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

    // Bus decode
    logic        selected;
    logic        rd_data_sel;
    logic        prev_q;
    logic        pop_req;
    logic        stat_wr;
    logic        ctrl_wr;
    logic [31:0] rdata;

    // Receiver
    logic [1:0]  sync_q;
    logic        rx_s;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        push_req;
    logic        frame_set;

    // FIFO and flags
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  not_empty, full;
    logic                  do_push, do_pop, overrun_set;
    logic                  frame_err_q, overrun_q;
    logic                  irq_en_q;

    assign selected    = request && (address >= BASE_ADDR) && (address <= BASE_ADDR + 32'd15);
    assign rd_data_sel = selected && !r_w && (address[1:0] == 2'b00);
    // Pop only on the first cycle of a DATA read, even if the request is held.
    assign pop_req     = rd_data_sel && !prev_q;
    assign stat_wr     = selected && r_w && (address[1:0] == 2'b01);
    assign ctrl_wr     = selected && r_w && (address[1:0] == 2'b10);

    assign ready_out = selected ? 1'b1 : 1'bz;
    assign data      = (selected && !r_w) ? rdata : 'z;

    assign rx_s = sync_q[1];

    // ---------------- RX FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // ---------------- RX FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (!rx_s) state_d = StStart;
            StStart:  if (cnt_q == CNT_HALF) state_d = rx_s ? StIdle : StData;
            StData:   if (cnt_q == CNT_LAST && bit_q == 3'd7) state_d = StStop;
            StStop:   if (cnt_q == CNT_LAST) state_d = rx_s ? StIdle : StWaitHi;
            StWaitHi: if (rx_s) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- RX FSM: outputs / datapath next values ----------------
    always_comb begin
        cnt_d     = cnt_q + 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
            end
            StStart: begin
                bit_d = '0;
                if (cnt_q == CNT_HALF) cnt_d = '0;
            end
            StData: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {rx_s, shift_q[7:1]};  // LSB first
                end
            end
            StStop: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    push_req  = rx_s;
                    frame_set = !rx_s;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], RxD};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= rd_data_sel;
        end
    end

    // ---------------- FIFO ----------------
    assign not_empty   = (count_q != '0);
    assign full        = count_q[DEPTH_LOG2];  // count can only reach DEPTH when full
    assign do_pop      = pop_req && not_empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
    assign do_push     = push_req && (!full || do_pop);
    assign overrun_set = push_req && full && !do_pop;
    assign RxD_ready   = not_empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            // Set wins over a same-cycle clear.
            if (frame_set)                frame_err_q <= 1'b1;
            else if (stat_wr && data[1])  frame_err_q <= 1'b0;
            if (overrun_set)              overrun_q <= 1'b1;
            else if (stat_wr && data[2])  overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_IRQ_EN
    logic unused_wdata;
    assign unused_wdata = ^data[31:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= data[0];
            irq <= irq_en_q && (not_empty || overrun_q);
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^{data[31:3], data[0], ctrl_wr};
    assign irq_en_q     = 1'b0;
`endif

    // ---------------- Read mux ----------------
    always_comb begin
        rdata = '0;
        case (address[1:0])
            2'b00:   if (not_empty) rdata = {23'b0, 1'b1, mem_q[rd_ptr_q]};
            2'b01:   rdata = {16'b0, 8'(count_q), 5'b0, overrun_q, frame_err_q, not_empty};
            2'b10:   rdata = {31'b0, irq_en_q};
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: directed bench for uart_rx_port with CLKS_PER_BIT=16 and a 4-deep FIFO.
// Bus reads push their expected data into a scoreboard queue; a monitor on the falling edge
// pops and compares whenever a read is on the bus.
module tb_uart_rx_port;

    localparam logic [31:0] A_DATA = 32'h3fffffe0;
    localparam logic [31:0] A_STAT = 32'h3fffffe1;
    localparam logic [31:0] A_CTRL = 32'h3fffffe2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    wire  [31:0] data;
    logic        request;
    logic        r_w;
    logic        ready_out;
    logic        rxd;
    logic        rxd_ready;
`ifdef UART_RX_IRQ_EN
    logic        irq;
`endif

    logic [31:0] tb_wdata;
    logic        tb_drive;
    logic        rd_active;

    assign data = tb_drive ? tb_wdata : 'z;

    int checks = 0;
    int errors = 0;

    string       name_q[$];
    logic [31:0] val_q[$];

    uart_rx_port #(
        .ClkFrequency(16),
        .Baud        (1),
        .DEPTH_LOG2  (2),
        .BASE_ADDR   (32'h3fffffe0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .data     (data),
        .request  (request),
        .r_w      (r_w),
        .ready_out(ready_out),
        .RxD      (rxd),
        .RxD_ready(rxd_ready)
`ifdef UART_RX_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_active) begin
            if (val_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got read %h expected no read", data);
            end else begin
                string       n;
                logic [31:0] v;
                n = name_q.pop_front();
                v = val_q.pop_front();
                check(n, data, v);
                check({n, "_ready"}, {31'b0, ready_out}, 32'd1);
            end
        end
    end

    // Read held for `cycles` clocks: first cycle expects `first`, later cycles expect `rest`.
    task automatic bus_read_held(input logic [31:0] addr, input int cycles,
                                 input logic [31:0] first, input logic [31:0] rest,
                                 input string name);
        @(posedge clk); #1;
        address = addr; r_w = 1'b0; request = 1'b1; rd_active = 1'b1;
        name_q.push_back(name);
        val_q.push_back(first);
        for (int i = 1; i < cycles; i++) begin
            name_q.push_back(name);
            val_q.push_back(rest);
        end
        repeat (cycles) @(posedge clk);
        #1;
        request = 1'b0; rd_active = 1'b0; address = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus_read_held(addr, 1, exp, 32'd0, name);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        address = addr; r_w = 1'b1; request = 1'b1; tb_wdata = wd; tb_drive = 1'b1;
        @(posedge clk); #1;
        request = 1'b0; tb_drive = 1'b0; r_w = 1'b0; address = '0;
    endtask

    task automatic drive(input logic v, input int n);
        @(posedge clk); #1;
        rxd = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        drive(stop, 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; address = '0; request = 1'b0; r_w = 1'b0; rxd = 1'b1;
        tb_wdata = '0; tb_drive = 1'b0; rd_active = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_rxd_ready", {31'b0, rxd_ready}, 32'd0);
        bus_read(A_STAT, 32'h0, "reset_stat");
        bus_read(A_DATA, 32'h0, "reset_data");

        // 1: single byte
        send_byte(8'hA5, 1'b1);
        check("t1_ready_hi", {31'b0, rxd_ready}, 32'd1);
        bus_read(A_STAT, 32'h101, "t1_stat");
        bus_read(A_DATA, 32'h1A5, "t1_data");
        check("t1_ready_lo", {31'b0, rxd_ready}, 32'd0);
        bus_read(A_STAT, 32'h0, "t1_stat_empty");

        // 2: held read pops once
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        bus_read_held(A_DATA, 5, 32'h111, 32'h122, "t2_hold");
        bus_read(A_DATA, 32'h122, "t2_next");
        bus_read(A_DATA, 32'h0, "t2_empty");

        // 3: overrun
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        bus_read(A_STAT, 32'h405, "t3_stat_full");
        bus_read(A_DATA, 32'h101, "t3_pop1");
        bus_read(A_DATA, 32'h102, "t3_pop2");
        bus_read(A_DATA, 32'h103, "t3_pop3");
        bus_read(A_DATA, 32'h104, "t3_pop4");
        bus_read(A_STAT, 32'h004, "t3_stat_ovr");
        bus_write(A_STAT, 32'h4);
        bus_read(A_STAT, 32'h0, "t3_stat_clr");

        // Full FIFO with a pop landing in the same cycle as the push: no overrun
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        fork
            send_byte(8'h14, 1'b1);
            begin
                repeat (155) @(posedge clk);
                bus_read(A_DATA, 32'h110, "full_pushpop");
            end
        join
        bus_read(A_STAT, 32'h401, "full_stat");
        bus_read(A_DATA, 32'h111, "full_pop1");
        bus_read(A_DATA, 32'h112, "full_pop2");
        bus_read(A_DATA, 32'h113, "full_pop3");
        bus_read(A_DATA, 32'h114, "full_pop4");

        // 4: framing error, line held low
        send_byte(8'h3C, 1'b0);
        bus_read(A_STAT, 32'h002, "t4_frame_err");
        repeat (40) @(posedge clk);
        check("t4_no_byte_low", {31'b0, rxd_ready}, 32'd0);
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(A_STAT, 32'h002, "t4_after_high");
        bus_write(A_STAT, 32'h2);
        bus_read(A_STAT, 32'h0, "t4_clr");
        send_byte(8'h5A, 1'b1);
        bus_read(A_DATA, 32'h15A, "t4_recover");

        // 5: glitch, then reset mid-frame
        drive(1'b0, 3);
        drive(1'b1, 40);
        bus_read(A_STAT, 32'h0, "t5_glitch");
        send_byte(8'h99, 1'b1);
        check("t5_preload", {31'b0, rxd_ready}, 32'd1);
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1'b0, 16);
        @(posedge clk); #1;
        rst = 1'b1; rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("t5_reset_ready", {31'b0, rxd_ready}, 32'd0);
        bus_read(A_STAT, 32'h0, "t5_reset_stat");
        repeat (200) @(posedge clk);
        bus_read(A_STAT, 32'h0, "t5_nothing_pushed");
        bus_read(A_DATA, 32'h0, "t5_data_empty");

`ifdef UART_RX_IRQ_EN
        // 6: interrupt
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h1, "t6_ctrl");
        check("t6_irq_idle", {31'b0, irq}, 32'd0);
        send_byte(8'h7E, 1'b1);
        check("t6_irq_set", {31'b0, irq}, 32'd1);
        bus_read(A_DATA, 32'h17E, "t6_pop");
        @(posedge clk); #1;
        check("t6_irq_clr", {31'b0, irq}, 32'd0);
`else
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h0, "ctrl_reads_zero");
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(val_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
